// File: rtl/challenge_attempt_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | challenge_attempt_ctrl                                                    |
// | Frames UART bytes into key attempts, checks the result, enforces lockout. |
// | Rev 1.0 - initial release                                                 |
// +---------------------------------------------------------------------------+
module challenge_attempt_ctrl #(
  parameter int          KEY_BYTES      = 8,
  parameter int          BYTE_TIMEOUT   = 8700,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 10000000,
  parameter logic [7:0]  RELOCK_BYTE    = 8'h1B
) (
  input  logic       clk_10,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       key_match,
  output logic       shift_en,
  output logic [7:0] shift_data,
  output logic       clear_key,
  output logic       unlocked,
  output logic       locked_out,
  output logic [3:0] fail_count
);

  localparam int c_idx_w  = $clog2(KEY_BYTES + 1);
  localparam int c_tmo_w  = $clog2(BYTE_TIMEOUT + 1);
  localparam int c_lock_w = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(KEY_BYTES);
  // Loaded one below the limit so clear_key lands BYTE_TIMEOUT cycles after the last byte.
  localparam logic [c_tmo_w-1:0]  c_tmo_load  = c_tmo_w'(BYTE_TIMEOUT - 1);
  localparam logic [c_lock_w-1:0] c_lock_load = c_lock_w'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]          c_fail_max  = 4'(MAX_FAILS);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_CHECK    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  state_t              r_state,    w_state_next;
  logic [c_idx_w-1:0]  r_idx,      w_idx_next;
  logic [c_tmo_w-1:0]  r_tmo,      w_tmo_next;
  logic [c_lock_w-1:0] r_lock,     w_lock_next;
  logic                r_chk_wait, w_chk_wait_next;
  logic [3:0]          r_fail,     w_fail_next;
  logic                r_shift_en, w_shift_en_next;
  logic [7:0]          r_shift_data;
  logic                r_clear,    w_clear_next;
  logic                r_unlocked, r_locked;
  logic                w_load_data;
  logic [c_idx_w-1:0]  w_idx_inc;
  logic [3:0]          w_fail_inc;

  assign w_idx_inc  = r_idx + 1'b1;
  assign w_fail_inc = r_fail + 4'd1;

  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_tmo_next      = r_tmo;
    w_lock_next     = r_lock;
    w_chk_wait_next = 1'b0;
    w_fail_next     = r_fail;
    w_shift_en_next = 1'b0;
    w_clear_next    = 1'b0;
    w_load_data     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (byte_valid) begin
          w_shift_en_next = 1'b1;
          w_load_data     = 1'b1;
          w_idx_next      = c_idx_w'(1);
          w_tmo_next      = c_tmo_load;
          w_state_next    = (KEY_BYTES == 1) ? ST_CHECK : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (byte_valid) begin
          w_shift_en_next = 1'b1;
          w_load_data     = 1'b1;
          w_idx_next      = w_idx_inc;
          w_tmo_next      = c_tmo_load;
          if (w_idx_inc == c_idx_last)
            w_state_next = ST_CHECK;
        end else if (r_tmo <= c_tmo_w'(1)) begin
          w_clear_next = 1'b1;
          w_idx_next   = '0;
          w_tmo_next   = '0;
          w_state_next = ST_IDLE;
        end else begin
          w_tmo_next = r_tmo - 1'b1;
        end
      end
      ST_CHECK: begin
        // First CHECK cycle overlaps the final shift; key_match is valid on the second.
        if (!r_chk_wait) begin
          w_chk_wait_next = 1'b1;
        end else begin
          w_idx_next = '0;
          w_tmo_next = '0;
          if (key_match) begin
            w_fail_next  = '0;
            w_state_next = ST_UNLOCKED;
          end else begin
            w_clear_next = 1'b1;
            w_fail_next  = w_fail_inc;
            if (w_fail_inc >= c_fail_max) begin
              w_lock_next  = c_lock_load;
              w_state_next = ST_LOCKOUT;
            end else begin
              w_state_next = ST_IDLE;
            end
          end
        end
      end
      ST_UNLOCKED: begin
        if (byte_valid && (byte_data == RELOCK_BYTE)) begin
          w_clear_next = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (r_lock == '0) begin
          w_clear_next = 1'b1;
          w_fail_next  = '0;
          w_state_next = ST_IDLE;
        end else begin
          w_lock_next = r_lock - 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_10 or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_tmo        <= '0;
      r_lock       <= '0;
      r_chk_wait   <= 1'b0;
      r_fail       <= '0;
      r_shift_en   <= 1'b0;
      r_shift_data <= '0;
      r_clear      <= 1'b0;
      r_unlocked   <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_tmo        <= w_tmo_next;
      r_lock       <= w_lock_next;
      r_chk_wait   <= w_chk_wait_next;
      r_fail       <= w_fail_next;
      r_shift_en   <= w_shift_en_next;
      r_clear      <= w_clear_next;
      r_unlocked   <= (w_state_next == ST_UNLOCKED);
      r_locked     <= (w_state_next == ST_LOCKOUT);
      if (w_load_data)
        r_shift_data <= byte_data;
    end
  end

  assign shift_en   = r_shift_en;
  assign shift_data = r_shift_data;
  assign clear_key  = r_clear;
  assign unlocked   = r_unlocked;
  assign locked_out = r_locked;
  assign fail_count = r_fail;

endmodule
`default_nettype wire
